// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//   Walks every input combination of each enabled function block on a shared
//   stimulus bus and compares the block's output with a golden truth table,
//   counting mismatches and recording the first one.
//
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start           begin a sweep (only honoured while idle)
//   dut_en          per-block enable, latched on start
//   narrow_mask     per-block "uses N_IN-1 inputs", latched on start
//   exp_tables      golden outputs, bit [i*2^N_IN + r] = block i, row r
//   dut_y           combinational outputs of the blocks
//   stim, dut_idx   stimulus bus and block currently under test
//   busy, done      not idle / one-cycle end-of-sweep pulse
//   pass            err_count was zero at the last done (held)
//   err_count       saturating mismatch count
//   first_fail_*    block and row of the first mismatch
//
// Build option
//   TTS_STOP_ON_FAIL_EN  when defined, the first mismatch ends the sweep at once
//                        with stim/dut_idx frozen on the failing row.

module truth_table_sweeper #(
  parameter int unsigned N_DUT = 8,
  parameter int unsigned N_IN  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [N_DUT-1:0]              dut_en,
  input  logic [N_DUT-1:0]              narrow_mask,
  input  logic [N_DUT*(2**N_IN)-1:0]    exp_tables,
  input  logic [N_DUT-1:0]              dut_y,
  output logic [N_IN-1:0]               stim,
  output logic [2:0]                    dut_idx,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [7:0]                    err_count,
  output logic [2:0]                    first_fail_dut,
  output logic [N_IN-1:0]               first_fail_row
);

  localparam int unsigned Rows = 2 ** N_IN;
  localparam int          PtrW = 4;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StScan   = 3'd1;
  localparam logic [2:0] StDrive  = 3'd2;
  localparam logic [2:0] StSample = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [N_DUT-1:0] en_q, en_d;
  logic [N_DUT-1:0] narrow_q, narrow_d;
  logic [PtrW-1:0]  ptr_q, ptr_d;
  logic [N_IN-1:0]  stim_q, stim_d;
  logic [2:0]       idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [7:0]       err_q, err_d;
  logic [2:0]       ffd_q, ffd_d;
  logic [N_IN-1:0]  ffr_q, ffr_d;

  // Lowest enabled block at or above the scan pointer.
  logic       found;
  logic [2:0] sel;
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = N_DUT - 1; i >= 0; i--) begin
      if (en_q[i] && (PtrW'(i) >= ptr_q)) begin
        found = 1'b1;
        sel   = 3'(i);
      end
    end
  end

  logic exp_bit;
  logic mismatch;
  logic last_row;
  logic stop_now;

  // {idx, stim} is exactly idx*2^N_IN + stim.
  assign exp_bit  = exp_tables[{idx_q, stim_q}];
  assign mismatch = (dut_y[idx_q] != exp_bit);
  assign last_row = narrow_q[idx_q] ? (stim_q == N_IN'(Rows / 2 - 1))
                                    : (stim_q == N_IN'(Rows - 1));
`ifdef TTS_STOP_ON_FAIL_EN
  assign stop_now = mismatch;
`else
  assign stop_now = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    narrow_d = narrow_q;
    ptr_d    = ptr_q;
    stim_d   = stim_q;
    idx_d    = idx_q;
    pass_d   = pass_q;
    err_d    = err_q;
    ffd_d    = ffd_q;
    ffr_d    = ffr_q;
    done_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          en_d     = dut_en;
          narrow_d = narrow_mask;
          err_d    = '0;
          ffd_d    = '0;
          ffr_d    = '0;
          pass_d   = 1'b0;
          ptr_d    = '0;
          state_d  = StScan;
        end
      end
      StScan: begin
        if (found) begin
          idx_d   = sel;
          stim_d  = '0;
          ptr_d   = {1'b0, sel} + 4'd1;
          state_d = StDrive;
        end else begin
          state_d = StDone;
        end
      end
      StDrive: state_d = StSample;
      StSample: begin
        if (mismatch) begin
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
          if (err_q == 8'd0) begin
            ffd_d = idx_q;
            ffr_d = stim_q;
          end
        end
        if (stop_now) begin
          state_d = StDone;
        end else if (last_row) begin
          state_d = StScan;
        end else begin
          stim_d  = stim_q + 1'b1;
          state_d = StDrive;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are registered, so done/pass are set on entry to DONE using the
    // count that already includes the final compare.
    if (state_d == StDone) begin
      done_d = 1'b1;
      pass_d = (err_d == 8'd0);
    end
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      en_q     <= '0;
      narrow_q <= '0;
      ptr_q    <= '0;
      stim_q   <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      ffd_q    <= '0;
      ffr_q    <= '0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      narrow_q <= narrow_d;
      ptr_q    <= ptr_d;
      stim_q   <= stim_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      ffd_q    <= ffd_d;
      ffr_q    <= ffr_d;
    end
  end

  assign stim           = stim_q;
  assign dut_idx        = idx_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_dut = ffd_q;
  assign first_fail_row = ffr_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: a trace model builds the expected per-cycle
// outputs of a sweep from the enable/narrow/table settings; a negedge process
// checks every cycle against it. Literal checks pin the done latency and
// final counts of each directed case.

module tb_truth_table_sweeper;

  localparam int ROWS = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [7:0]   dut_en;
  logic [7:0]   narrow_mask;
  logic [127:0] exp_tables;
  logic [127:0] beh_tab;
  logic [7:0]   dut_y;
  logic [3:0]   stim;
  logic [2:0]   dut_idx;
  logic         busy;
  logic         done;
  logic         pass;
  logic [7:0]   err_count;
  logic [2:0]   first_fail_dut;
  logic [3:0]   first_fail_row;

  always #5 clk = ~clk;

  truth_table_sweeper #(.N_DUT(8), .N_IN(4)) u_dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .dut_en         (dut_en),
    .narrow_mask    (narrow_mask),
    .exp_tables     (exp_tables),
    .dut_y          (dut_y),
    .stim           (stim),
    .dut_idx        (dut_idx),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_fail_dut (first_fail_dut),
    .first_fail_row (first_fail_row)
  );

  // Function blocks: each block's real behaviour is a 16-row table.
  always_comb begin
    dut_y = '0;
    for (int i = 0; i < 8; i++) dut_y[i] = beh_tab[i * ROWS + int'(stim)];
  end

  typedef struct {
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] stim;
    logic [2:0] idx;
    logic [7:0] err;
    logic [2:0] ffd;
    logic [3:0] ffr;
  } ent_t;

  ent_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   done_cyc = 0;

  // Visible output values of the model.
  logic       m_pass;
  logic [3:0] m_stim;
  logic [2:0] m_idx;
  int         m_err;
  logic [2:0] m_ffd;
  logic [3:0] m_ffr;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push(input logic b, input logic d);
    ent_t e;
    e.busy = b;
    e.done = d;
    e.pass = m_pass;
    e.stim = m_stim;
    e.idx  = m_idx;
    e.err  = 8'(m_err);
    e.ffd  = m_ffd;
    e.ffr  = m_ffr;
    q.push_back(e);
  endtask

  task automatic model_zero();
    m_pass = 0; m_stim = 0; m_idx = 0; m_err = 0; m_ffd = 0; m_ffr = 0;
  endtask

  // Expected cycles from the first cycle after start is accepted.
  task automatic model_build(input logic [7:0] en, input logic [7:0] narrow);
    bit stop = 0;
    m_err = 0; m_pass = 0; m_ffd = 0; m_ffr = 0;
    push(1, 0);  // first scan
    for (int i = 0; i < 8; i++) begin
      if (en[i] && !stop) begin
        int nrows = narrow[i] ? ROWS / 2 : ROWS;
        m_idx = 3'(i);
        for (int r = 0; r < nrows && !stop; r++) begin
          bit mis;
          m_stim = 4'(r);
          push(1, 0);  // settle
          push(1, 0);  // compare
          mis = beh_tab[i * ROWS + r] != exp_tables[i * ROWS + r];
          if (mis) begin
            if (m_err == 0) begin m_ffd = 3'(i); m_ffr = 4'(r); end
            if (m_err < 255) m_err++;
`ifdef TTS_STOP_ON_FAIL_EN
            stop = 1;
`endif
          end
        end
        if (!stop) push(1, 0);  // scan after the block
      end
    end
    m_pass = (m_err == 0);
    push(1, 1);  // done
    push(0, 0);  // idle, results held
    push(0, 0);
  endtask

  always @(negedge clk) begin
    ent_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      cyc++;
      if (done && done_cyc == 0) done_cyc = cyc;
      chk("busy", int'(busy), int'(e.busy));
      chk("done", int'(done), int'(e.done));
      chk("pass", int'(pass), int'(e.pass));
      chk("stim", int'(stim), int'(e.stim));
      chk("dut_idx", int'(dut_idx), int'(e.idx));
      chk("err_count", int'(err_count), int'(e.err));
      chk("first_fail_dut", int'(first_fail_dut), int'(e.ffd));
      chk("first_fail_row", int'(first_fail_row), int'(e.ffr));
    end
  end

  task automatic drain(input string name);
    bit ok = 0;
    for (int g = 0; g < 200; g++) begin
      @(posedge clk); #2;
      if (q.size() == 0) begin ok = 1; break; end
    end
    if (!ok) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic do_reset();
    reset = 1; start = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    model_zero();
    push(0, 0);
    push(0, 0);
    drain("reset");
  endtask

  // poke: raise start while busy; abort_at: assert reset at that cycle.
  task automatic run_sweep(input string name, input logic [7:0] en, input logic [7:0] narrow,
                           input bit poke, input int abort_at, input int exp_done);
    bit ok = 0;
    bit aborted = 0;
    @(negedge clk);
    dut_en = en; narrow_mask = narrow; start = 1;
    @(posedge clk); #1;
    start = 0;
    dut_en = ~en; narrow_mask = ~narrow;  // must be ignored mid-sweep
    cyc = 0; done_cyc = 0;
    model_build(en, narrow);
    for (int g = 0; g < 3000; g++) begin
      @(posedge clk); #2;
      start = poke && cyc >= 3 && cyc <= 5;
      if (abort_at != 0 && cyc == abort_at && !aborted) begin
        aborted = 1;
        chk({name, "_abort_stim"}, int'(stim), 5);
        chk({name, "_abort_idx"}, int'(dut_idx), 1);
        q.delete();
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        model_zero();
        push(0, 0); push(0, 0); push(0, 0);
      end
      if (q.size() == 0) begin ok = 1; break; end
    end
    start = 0;
    if (!ok) chk({name, "_timeout"}, 0, 1);
    if (exp_done >= 0) chk({name, "_done_cycle"}, done_cyc, exp_done);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; start = 0; dut_en = 0; narrow_mask = 0;
    exp_tables = '0; beh_tab = '0;
    model_zero();
    do_reset();

    // 3-input AND on block 0.
    exp_tables = {112'h0, 16'h0080};
    beh_tab    = exp_tables;
    run_sweep("and3", 8'h01, 8'h01, 0, 0, 19);
    chk("and3_pass", int'(pass), 1);
    chk("and3_err", int'(err_count), 0);

    // Nothing enabled.
    run_sweep("none", 8'h00, 8'h00, 0, 0, 2);
    chk("none_pass", int'(pass), 1);

    // start pulsed while busy must not restart.
    run_sweep("restart", 8'h01, 8'h01, 1, 0, 19);

    // Full sweep, half narrow.
    exp_tables = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    beh_tab    = exp_tables;
    run_sweep("full", 8'hFF, 8'hF0, 0, 0, 202);
    chk("full_pass", int'(pass), 1);
    chk("full_last_idx", int'(dut_idx), 7);

    // Block 2 stuck at 0, table ones at rows 3, 9, 11.
    exp_tables = {80'h0, 16'h0A08, 16'h8000, 16'h6996};
    beh_tab    = {80'h0, 16'h0000, 16'h8000, 16'h6996};
`ifdef TTS_STOP_ON_FAIL_EN
    run_sweep("stuck", 8'h07, 8'h00, 0, 0, 76);
    chk("stuck_err", int'(err_count), 1);
    chk("stuck_stim", int'(stim), 3);
`else
    run_sweep("stuck", 8'h07, 8'h00, 0, 0, 101);
    chk("stuck_err", int'(err_count), 3);
`endif
    chk("stuck_ffd", int'(first_fail_dut), 2);
    chk("stuck_ffr", int'(first_fail_row), 3);
    chk("stuck_pass", int'(pass), 0);

    // Reset during block 1 row 5, then a clean sweep.
    exp_tables = 128'hDEAD_BEEF_0F0F_F0F0_1357_9BDF_2468_ACE0;
    beh_tab    = exp_tables;
    run_sweep("abort", 8'h03, 8'h00, 0, 45, 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_err", int'(err_count), 0);
    run_sweep("after_abort", 8'h03, 8'h00, 0, 0, 68);
    chk("after_abort_pass", int'(pass), 1);

    // Every block inverted against its table.
    beh_tab = ~exp_tables;
`ifdef TTS_STOP_ON_FAIL_EN
    run_sweep("invert", 8'hFF, 8'h00, 0, 0, 4);
    chk("invert_err", int'(err_count), 1);
`else
    run_sweep("invert", 8'hFF, 8'h00, 0, 0, 266);
    chk("invert_err", int'(err_count), 128);
`endif
    chk("invert_pass", int'(pass), 0);
    chk("invert_ffd", int'(first_fail_dut), 0);
    chk("invert_ffr", int'(first_fail_row), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
